sym_dn_lut_load_ctrl: RTL and testbench

//  Sequences runtime reloads of the 128x1 symmetric DN LUT RAM pair (4 async read ports; ports 1/3 share the write address).

---
 rtl/sym_dn_lut_load_ctrl_if.sv | 10 +
 rtl/sym_dn_lut_load_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sym_dn_lut_load_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sym_dn_lut_load_ctrl_if.sv
// Serial LUT-reload stream: one entry bit per valid/ready handshake.
// The host side is the master, the load controller is the slave.
interface sym_dn_lut_load_ctrl_if;
    logic ld_valid;
    logic ld_bit;
    logic ld_ready;

    modport master (output ld_valid, output ld_bit, input ld_ready);
    modport slave  (input ld_valid, input ld_bit, output ld_ready);
endinterface

// File: rtl/sym_dn_lut_load_ctrl.sv
// Reload sequencer for the symmetric DN LUT RAM pair: takes LUT ownership from the decoder,
// streams DEPTH bits into the LUT, then hands ownership back. Optional macro: DN_LUT_PARITY_EN.
module sym_dn_lut_load_ctrl #(
    parameter int ADDR_W       = 7,
    parameter int DEPTH        = 128,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                      sys_clk,
    input  logic                      rstn,
    input  logic                      load_req,
    input  logic                      rd_req,
    output logic                      rd_gnt,
    sym_dn_lut_load_ctrl_if.slave     ld,
    output logic                      lut_we,
    output logic                      lut_in,
    output logic [ADDR_W-1:0]         write_addr,
    output logic                      busy,
    output logic                      load_done,
    output logic                      load_err,
    input  logic                      exp_parity,
    output logic                      parity_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_RD = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_FLUSH   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int CNT_W = ADDR_W + 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic              ld_ready_q, ld_ready_d;
    logic              lut_we_q, lut_we_d;
    logic              lut_in_q, lut_in_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hs;

    assign hs = ld.ld_valid & ld_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drn_d      = drn_q;
        rd_gnt_d   = rd_gnt_q;
        ld_ready_d = ld_ready_q;
        lut_we_d   = 1'b0;
        lut_in_d   = lut_in_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = load_req & (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d  = S_WAIT_RD;
                    rd_gnt_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_WAIT_RD: begin
                if (!rd_req) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d    = S_WRITE;
                        ld_ready_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = S_DRAIN;
                        drn_d   = DRN_INIT;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == '0) begin
                    state_d    = S_WRITE;
                    ld_ready_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            S_WRITE: begin
                // Ready drops together with the last accepted bit, so nothing past DEPTH gets in.
                if (hs) begin
                    lut_we_d = 1'b1;
                    lut_in_d = ld.ld_bit;
                    addr_d   = cnt_q[ADDR_W-1:0];
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        ld_ready_d = 1'b0;
                        state_d    = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rd_gnt_d = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                rd_gnt_d   = 1'b1;
                ld_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drn_q      <= '0;
            rd_gnt_q   <= 1'b1;
            ld_ready_q <= 1'b0;
            lut_we_q   <= 1'b0;
            lut_in_q   <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drn_q      <= drn_d;
            rd_gnt_q   <= rd_gnt_d;
            ld_ready_q <= ld_ready_d;
            lut_we_q   <= lut_we_d;
            lut_in_q   <= lut_in_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rd_gnt      = rd_gnt_q;
    assign ld.ld_ready = ld_ready_q;
    assign lut_we      = lut_we_q;
    assign lut_in      = lut_in_q;
    assign write_addr  = addr_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign load_err    = err_q;

`ifdef DN_LUT_PARITY_EN
    logic acc_q, acc_d;
    logic exp_q, exp_d;
    logic perr_q, perr_d;

    // Accumulator is final in FLUSH, so the verdict lands in DONE alongside load_done.
    always_comb begin
        acc_d  = acc_q;
        exp_d  = exp_q;
        perr_d = 1'b0;
        if (state_q == S_IDLE && load_req) begin
            acc_d = 1'b0;
            exp_d = exp_parity;
        end
        if (state_q == S_WRITE && hs) begin
            acc_d = acc_q ^ ld.ld_bit;
        end
        if (state_q == S_FLUSH) begin
            perr_d = acc_q ^ exp_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            acc_q  <= 1'b0;
            exp_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            exp_q  <= exp_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    logic unused_exp_parity;
    assign unused_exp_parity = exp_parity;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sym_dn_lut_load_ctrl.sv
// Directed bench for sym_dn_lut_load_ctrl: idle after reset, continuous and stalled loads,
// decoder hold, busy-time load_req, mid-load reset, and parity (when DN_LUT_PARITY_EN is set).
module tb_sym_dn_lut_load_ctrl;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;
    localparam int DRAIN  = 2;
`ifdef DN_LUT_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              load_req;
    logic              rd_req;
    logic              rd_gnt;
    logic              lut_we;
    logic              lut_in;
    logic [ADDR_W-1:0] write_addr;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic              exp_parity;
    logic              parity_err;

    sym_dn_lut_load_ctrl_if ld_if ();

    sym_dn_lut_load_ctrl #(
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .sys_clk    (clk),
        .rstn       (rstn),
        .load_req   (load_req),
        .rd_req     (rd_req),
        .rd_gnt     (rd_gnt),
        .ld         (ld_if),
        .lut_we     (lut_we),
        .lut_in     (lut_in),
        .write_addr (write_addr),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .exp_parity (exp_parity),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   sent = 0;
    int   wexp = 0;
    int   first_we = 0;
    int   last_we = 0;
    int   rdy_cyc = 0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic tog = 1'b0;
    logic all_ones = 1'b0;
    logic mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance, then check the registered write port against the stream model.
    task automatic step();
        logic hs;
        logic bexp;
        hs = ld_if.ld_valid & ld_if.ld_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) sent++;
        chk("we_follows_hs", {31'd0, lut_we}, {31'd0, hs});
        chk("gnt_we_excl", {31'd0, rd_gnt & lut_we}, 32'd0);
        chk("perr_only_with_done", {31'd0, parity_err & ~load_done}, 32'd0);
        if (ld_if.ld_ready) rdy_cyc++;
        if (lut_we) begin
            bexp = all_ones ? 1'b1 : wexp[0];
            chk("wr_addr", {25'd0, write_addr}, wexp);
            chk("wr_data", {31'd0, lut_in}, {31'd0, bexp});
            if (write_addr < DEPTH) mem[write_addr] = lut_in;
            if (wexp == 0) first_we = cyc;
            last_we   = cyc;
            hold_addr = write_addr;
            wexp++;
        end else begin
            chk("addr_hold", {25'd0, write_addr}, {25'd0, hold_addr});
        end
        if (tog) ld_if.ld_valid = ~ld_if.ld_valid;
        ld_if.ld_bit = all_ones ? 1'b1 : sent[0];
    endtask

    task automatic start_load(input logic rdq, input logic expp);
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'bx;
        sent         = 0;
        wexp         = 0;
        rdy_cyc      = 0;
        ld_if.ld_bit = all_ones;
        rd_req       = rdq;
        exp_parity   = expp;
        load_req     = 1'b1;
        step();
        load_req = 1'b0;
        chk("start_gnt", {31'd0, rd_gnt}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_load(input logic exp_perr);
        int n;
        int bad;
        n = 0;
        while (!load_done && n < 2000) begin
            step();
            n++;
        end
        chk("done_seen", {31'd0, load_done}, 32'd1);
        chk("done_lat", cyc - last_we, 32'd1);
        chk("done_count", wexp, DEPTH);
        chk("done_gnt", {31'd0, rd_gnt}, 32'd0);
        chk("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
        step();
        chk("post_gnt", {31'd0, rd_gnt}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_done", {31'd0, load_done}, 32'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== (all_ones ? 1'b1 : i[0])) bad++;
        end
        chk("mem_content_bad", bad, 32'd0);
    endtask

    initial begin
        int n;
        rstn           = 1'b0;
        load_req       = 1'b0;
        rd_req         = 1'b0;
        exp_parity     = 1'b0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_bit   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {31'd0, rd_gnt}, 32'd1);
        chk("rst_ready", {31'd0, ld_if.ld_ready}, 32'd0);
        rstn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_vec", {25'd0, rd_gnt, lut_we, busy, ld_if.ld_ready, load_done, load_err, parity_err},
                32'b1000000);
            chk("idle_addr", {25'd0, write_addr}, 32'd0);
        end

        // Continuous stream, addr[0] data.
        tog = 1'b0;
        all_ones = 1'b0;
        ld_if.ld_valid = 1'b1;
        start_load(1'b0, 1'b0);
        finish_load(1'b0);
        chk("cont_span", last_we - first_we + 1, DEPTH);

        // Decoder holds reads 10 cycles (request taken while rd_req=1); stream toggles.
        tog = 1'b1;
        ld_if.ld_valid = 1'b1;
        start_load(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_gnt", {31'd0, rd_gnt}, 32'd0);
            chk("hold_ready", {31'd0, ld_if.ld_ready}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        rd_req = 1'b0;
        n = 0;
        while (!ld_if.ld_ready && n < 20) begin
            step();
            n++;
        end
        chk("drain_lat", n, 1 + DRAIN);
        finish_load(1'b0);
        chk("toggle_write_cycles_ok", {31'd0, (rdy_cyc >= 255) && (rdy_cyc <= 256)}, 32'd1);

        // Second load_req while busy at addr 40.
        tog = 1'b0;
        ld_if.ld_valid = 1'b1;
        start_load(1'b0, 1'b0);
        n = 0;
        while (!(lut_we && write_addr == 7'd40) && n < 300) begin
            step();
            n++;
        end
        chk("reach_addr40", {25'd0, write_addr}, 32'd40);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("load_err_pulse", {31'd0, load_err}, 32'd1);
        step();
        chk("load_err_clear", {31'd0, load_err}, 32'd0);
        chk("busy_after_err", {31'd0, busy}, 32'd1);
        finish_load(1'b0);

        // Reset mid-load at addr 60.
        start_load(1'b0, 1'b0);
        n = 0;
        while (!(lut_we && write_addr == 7'd60) && n < 300) begin
            step();
            n++;
        end
        chk("reach_addr60", {25'd0, write_addr}, 32'd60);
        rstn = 1'b0;
        #1;
        chk("arst_we", {31'd0, lut_we}, 32'd0);
        chk("arst_gnt", {31'd0, rd_gnt}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, ld_if.ld_ready}, 32'd0);
        chk("arst_addr", {25'd0, write_addr}, 32'd0);
        ld_if.ld_valid = 1'b0;
        hold_addr = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_gnt", {31'd0, rd_gnt}, 32'd1);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        // All-ones loads: XOR of 128 ones is 0.
        all_ones = 1'b1;
        ld_if.ld_valid = 1'b1;
        start_load(1'b0, 1'b0);
        finish_load(1'b0);
        start_load(1'b0, 1'b1);
        finish_load(PAR_EN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
